// File: rtl/stash_pkg.sv
// Shared types and modular pointer helpers for the lap-stash controller.
package stash_pkg;

  typedef enum logic [1:0] {REC, ALIGN, BROWSE, STEP} state_t;

  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int mod_inc(input int v, input int depth);
    return (v + 1 >= depth) ? 0 : v + 1;
  endfunction

  // Operands are always already reduced mod depth, so no divider is needed.
  function automatic int mod_sub(input int a, input int b, input int depth);
    return (a >= b) ? a - b : a + depth - b;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// One-bit rising-edge detector; a held level yields a single-cycle pulse.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/stash_ctrl.sv
// Sequences a Stash circular buffer: records laps, then walks the valid
// entries oldest to newest by pulsing Stash's read-advance strobe.
module stash_ctrl
  import stash_pkg::*;
#(
  parameter int DEPTH       = 5,
  parameter int WIDTH       = 8,
  parameter int AUTO_SCROLL = 0,
  localparam int CW         = stash_pkg::cw_of(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lap_req,
  input  logic             browse_req,
  input  logic             next_req,
  input  logic             auto_tick,
  input  logic [WIDTH-1:0] time_in,
  output logic [WIDTH-1:0] sample_in,
  output logic             sample_in_valid,
  output logic             next_sample,
  output logic             browsing,
  output logic             busy,
  output logic [CW-1:0]    entry_count,
  output logic [CW-1:0]    view_idx
);

  localparam logic AUTO_EN = (AUTO_SCROLL != 0);

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_m, rd_m, tgt_q, tgt_d;
  logic [CW-1:0]   oldest, rel;
  logic            rise_lap, rise_browse, rise_next;
  logic            lap_wr, at_last, step_ev;

  btn_edge u_lap    (.clk(clk), .reset(reset), .d(lap_req),    .rise(rise_lap));
  btn_edge u_browse (.clk(clk), .reset(reset), .d(browse_req), .rise(rise_browse));
  btn_edge u_next   (.clk(clk), .reset(reset), .d(next_req),   .rise(rise_next));

  // Once the buffer has wrapped, the next slot to be written holds the oldest lap.
  assign oldest   = (entry_count == CW'(DEPTH)) ? wr_m : '0;
  assign rel      = CW'(mod_sub(int'(rd_m), int'(oldest), DEPTH));
  assign at_last  = (rel == entry_count - CW'(1));
  assign step_ev  = rise_next | (AUTO_EN & auto_tick);

  assign browsing = (state_q != REC);
  assign busy     = (state_q == ALIGN) || (state_q == STEP);
  assign view_idx = browsing ? rel : '0;

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    next_sample = 1'b0;
    lap_wr      = 1'b0;
    case (state_q)
      REC: begin
        if (rise_lap)
          lap_wr = 1'b1;
        else if (rise_browse && (entry_count != '0))
          state_d = ALIGN;
      end
      // Compared against live oldest so a write landing on entry is honoured.
      ALIGN: begin
        if (rd_m != oldest) next_sample = 1'b1;
        else                state_d     = BROWSE;
      end
      BROWSE: begin
        if (rise_browse) begin
          state_d = REC;
        end else if (step_ev) begin
          state_d = STEP;
          tgt_d   = at_last ? oldest : CW'(mod_inc(int'(rd_m), DEPTH));
        end
      end
      STEP: begin
        if (rd_m != tgt_q) next_sample = 1'b1;
        else               state_d     = BROWSE;
      end
      default: state_d = REC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= REC;
      tgt_q           <= '0;
      wr_m            <= '0;
      rd_m            <= '0;
      entry_count     <= '0;
      sample_in       <= '0;
      sample_in_valid <= 1'b0;
    end else begin
      state_q         <= state_d;
      tgt_q           <= tgt_d;
      sample_in_valid <= lap_wr;
      if (lap_wr) sample_in <= time_in;
      if (sample_in_valid) begin
        wr_m <= CW'(mod_inc(int'(wr_m), DEPTH));
        if (entry_count != CW'(DEPTH)) entry_count <= entry_count + CW'(1);
      end
      if (next_sample) rd_m <= CW'(mod_inc(int'(rd_m), DEPTH));
    end
  end

endmodule

// File: doc/stash_ctrl.md
Name: stash_ctrl

Overview:
- Controller that sequences one Stash circular buffer (DEPTH entries, WIDTH-bit samples) for the stopwatch lap feature.
- In record mode it captures the current time into Stash on each lap press.
- In browse mode it drives Stash's next_sample so the display steps oldest→newest over valid entries only, wrapping at the entry count rather than at DEPTH.
- Sits between the button edge/tick logic and Stash; sample_out is read directly from Stash.

Parameters:
DEPTH, 5, Stash depth; must equal the Stash DEPTH parameter
WIDTH, 8, sample width
AUTO_SCROLL, 0, 1 = auto_tick also advances the view in browse mode
CW (localparam), $clog2(DEPTH+1), counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
lap_req  in  1  level; rising edge = store time
browse_req  in  1  level; rising edge = toggle record/browse
next_req  in  1  level; rising edge = show next entry
auto_tick  in  1  single-cycle enable for auto-scroll
time_in  in  WIDTH  current stopwatch value
sample_in  out  WIDTH  data to Stash
sample_in_valid  out  1  one-cycle write strobe to Stash
next_sample  out  1  read-advance strobe to Stash
browsing  out  1  high in ALIGN/BROWSE/STEP
busy  out  1  high in ALIGN/STEP
entry_count  out  CW  valid entries, saturates at DEPTH
view_idx  out  CW  displayed entry, 0 = oldest; 0 outside browse

Behaviour:
- Reset (reset=0, asynchronous): state=REC; all outputs 0; wr_m=rd_m=0; edge registers 0. Stash must share this reset so the pointer mirrors match it.
- Edge detect: rise_x = x & ~x_q, where x_q is registered every cycle. Requests are edges only; holding a button high produces one event.
- Pointer mirrors:
  - wr_m increments on sample_in_valid; rd_m increments on next_sample; both wrap DEPTH-1→0.
  - entry_count increments per write and saturates at DEPTH.
  - oldest = (entry_count==DEPTH) ? wr_m : 0.
  - view_idx = (rd_m − oldest) mod DEPTH while browsing.
- REC:
  - rise_lap in cycle n → cycle n+1: sample_in_valid=1 for exactly one cycle, sample_in = time_in sampled in cycle n. sample_in holds its value afterwards.
  - rise_browse with entry_count>0 → ALIGN with target=oldest. With entry_count==0 it is ignored.
  - rise_lap and rise_browse in the same cycle: lap is performed, browse is dropped.
- ALIGN / STEP:
  - next_sample=1 in every cycle where rd_m≠target; when rd_m==target → BROWSE.
  - Pulse count = (target − rd_m) mod DEPTH, at one pulse per cycle.
  - Zero distance: one busy cycle, no pulse.
  - All request edges arriving while busy are discarded.
- BROWSE:
  - rise_next, or auto_tick when AUTO_SCROLL=1 → STEP.
  - STEP target = oldest if view_idx==entry_count−1, else (rd_m+1) mod DEPTH.
  - rise_next and auto_tick in the same cycle count as one step.
  - rise_browse → REC, no pulses; rd_m is kept.
  - rise_lap is ignored: no write, entry_count unchanged.
- Overflow: laps beyond DEPTH overwrite the oldest entry (Stash behaviour). entry_count stays DEPTH and oldest tracks wr_m.
- sample_in_valid and next_sample are never high in the same cycle.
- Reset asserted mid-ALIGN/STEP: outputs clear immediately with no further pulses.

Decomposition:
- Shared package stash_pkg: state enum {REC, ALIGN, BROWSE, STEP}; a mod-DEPTH increment/subtract function; CW width calculation.
- One natural sub-module, btn_edge: 1-bit rising-edge detector, instantiated three times (lap, browse, next).
- FSM and pointer mirrors stay in stash_ctrl.

Test Plan:
1. DEPTH=5. Laps with time_in 10,20,30, then browse:
   - Entering browse gives 0 align pulses; sample_out=10, view_idx=0.
   - next → 20, then 30.
   - Next next gives exactly 3 consecutive next_sample pulses → sample_out=10, view_idx=0.
2. Laps 10..70 (7 writes):
   - entry_count=5, wr_m=2.
   - browse → exactly 2 align pulses, sample_out=30.
   - 5 nexts → 40, 50, 60, 70, 30, each with 1 pulse.
3. lap_req held high 4 cycles → exactly one sample_in_valid; entry_count +1; sample_in = time_in from the edge cycle.
4. browse with entry_count=0 → browsing stays 0. Then lap during BROWSE → no sample_in_valid, entry_count unchanged. next during STEP (busy=1) → discarded.
5. Reset driven low mid-ALIGN (2-pulse case of scenario 2) → next_sample, browsing and busy go 0 asynchronously; after release state=REC, entry_count=0.
6. AUTO_SCROLL=1, 3 entries, auto_tick every 8 cycles with next_req pressed in the same cycle as one tick → view_idx sequence 0,1,2,0 with a single step at the coincident cycle.
